// File: rtl/div_meter.sv
// div_meter: measures edge count, edge-to-edge period range and high time of an async input
// over a fixed gate window of clk cycles; all result counters saturate.
module div_meter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max,
    output logic [CNT_W-1:0] high_cnt,
    output logic             period_valid,
    output logic             sat
);
    localparam int GW = $clog2(GATE_CYCLES);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MEAS, DONE} state_t;
    state_t r_state, w_state_n;

    logic r_s1, r_s2, r_s3, w_rise;
    logic [CNT_W-1:0] r_edge, r_high, r_pmin, r_pmax, r_ptimer;
    logic [GW-1:0] r_gate;
    logic r_first, r_sat;
    logic [CNT_W:0] w_edge_inc, w_high_inc, w_ptimer_inc;
    logic [CNT_W-1:0] w_edge_n, w_high_n, w_pmin_n, w_pmax_n, w_ptimer_n, w_period;
    logic w_sat_n, w_last, w_upd, w_valid;

    // returns {clamped, result}
    function automatic logic [CNT_W:0] inc_sat(input logic [CNT_W-1:0] a, input logic inc);
        return (inc && a == MAX) ? {1'b1, a} : {1'b0, a + CNT_W'(inc)};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = IDLE;
        case (r_state)
            IDLE:    w_state_n = start ? MEAS : IDLE;
            MEAS:    w_state_n = w_last ? DONE : MEAS;
            default: w_state_n = IDLE;
        endcase
    end

    assign busy = r_state == MEAS;
    assign done = r_state == DONE;

    always_comb begin
        w_last       = r_state == MEAS && r_gate == LAST;
        w_upd        = w_rise & r_first;
        w_edge_inc   = inc_sat(r_edge, w_rise);
        w_high_inc   = inc_sat(r_high, r_s2);
        w_ptimer_inc = inc_sat(r_ptimer, 1'b1);
        w_period     = w_ptimer_inc[CNT_W-1:0];
        w_edge_n     = w_edge_inc[CNT_W-1:0];
        w_high_n     = w_high_inc[CNT_W-1:0];
        w_ptimer_n   = w_rise ? '0 : r_first ? w_period : r_ptimer;
        w_pmin_n     = (w_upd && w_period < r_pmin) ? w_period : r_pmin;
        w_pmax_n     = (w_upd && w_period > r_pmax) ? w_period : r_pmax;
        // the timer only counts (and can clamp) once the first edge has been seen
        w_sat_n      = r_sat | w_edge_inc[CNT_W] | w_high_inc[CNT_W] | (r_first & w_ptimer_inc[CNT_W]);
        w_valid      = w_edge_n >= CNT_W'(2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edge   <= '0;
            r_high   <= '0;
            r_pmin   <= '1;
            r_pmax   <= '0;
            r_ptimer <= '0;
            r_gate   <= '0;
            r_first  <= 1'b0;
            r_sat    <= 1'b0;
        end else if (r_state == IDLE && start) begin
            r_edge   <= '0;
            r_high   <= '0;
            r_pmin   <= '1;
            r_pmax   <= '0;
            r_ptimer <= '0;
            r_gate   <= '0;
            r_first  <= 1'b0;
            r_sat    <= 1'b0;
        end else if (r_state == MEAS) begin
            r_edge   <= w_edge_n;
            r_high   <= w_high_n;
            r_pmin   <= w_pmin_n;
            r_pmax   <= w_pmax_n;
            r_ptimer <= w_ptimer_n;
            r_gate   <= r_gate + 1'b1;
            r_first  <= r_first | w_rise;
            r_sat    <= w_sat_n;
        end
    end

    // results are captured from the final sample so they are valid while done is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt     <= '0;
            period_min   <= '0;
            period_max   <= '0;
            high_cnt     <= '0;
            period_valid <= 1'b0;
            sat          <= 1'b0;
        end else if (w_last) begin
            edge_cnt     <= w_edge_n;
            period_min   <= w_valid ? w_pmin_n : '0;
            period_max   <= w_pmax_n;
            high_cnt     <= w_high_n;
            period_valid <= w_valid;
            sat          <= w_sat_n;
        end
    end
endmodule

// File: doc/div_meter.md
# div_meter

Measurement stage downstream of the half-integer clock divider. It samples the divider output (`sig_in`, asynchronous to `clk`) and, over a programmable gate window of `clk` cycles, reports:
- the rising-edge count;
- the minimum and maximum edge-to-edge period;
- the number of cycles `sig_in` spends high.

It lets benches and on-chip self-test confirm divide ratio and duty cycle without waveform inspection.

## Interface
- `GATE_CYCLES`, 1000: length of the measurement window in `clk` cycles (≥ 2).
- `CNT_W`, 16: width of all result counters; every counter saturates at 2^CNT_W−1.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sig_in`  in  1  signal under test (asynchronous to `clk`).
- `start`  in  1  request a measurement; sampled only in IDLE.
- `busy`  out  1  high from the cycle after accepted `start` until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse; results valid from this cycle.
- `edge_cnt`  out  CNT_W  rising edges detected in the window.
- `period_min`  out  CNT_W  shortest edge-to-edge interval, in `clk` cycles.
- `period_max`  out  CNT_W  longest edge-to-edge interval, in `clk` cycles.
- `high_cnt`  out  CNT_W  window cycles with synchronized `sig_in` = 1.
- `period_valid`  out  1  at least two edges were seen (min/max meaningful).
- `sat`  out  1  any counter saturated during the window.

## Operation
- **Input path:** two-flop synchronizer on `sig_in`, then a third flop for edge detection. A rising edge is `s2 & ~s3`.
- **FSM states:** IDLE, MEAS, DONE.
- **IDLE → MEAS:** on `start` = 1.
  - Clear working counters: `edge`, `high`, `gate` = 0; `pmin` = all-ones; `pmax` = 0; `ptimer` = 0; `first_seen` = 0; `sat_w` = 0.
- **MEAS:** runs for exactly GATE_CYCLES cycles, counted by `gate`.
  - Each cycle:
    - `high` += `s2`.
    - `ptimer` += 1, only once `first_seen` = 1.
  - On a detected edge:
    - `edge` += 1.
    - If `first_seen`: update `pmin`/`pmax` with `ptimer`+1, then reload `ptimer` = 0.
    - Otherwise set `first_seen` and `ptimer` = 0.
  - Saturating add everywhere. Any clamp sets `sat_w`.
- **MEAS → DONE:** in the cycle where `gate` = GATE_CYCLES−1; that cycle's sample is still included.
- **DONE:** copy working counters to outputs.
  - `period_valid` = (`edge` ≥ 2).
  - `period_min` forced to 0 when not valid.
  - Pulse `done`; next state IDLE.
- Outputs hold their last results until the next DONE.
- `start` during MEAS/DONE is ignored (not queued).

## Timing
- **Reset:** state IDLE, synchronizer flops 0. All outputs 0: `busy`, `done`, `edge_cnt`, `period_min`, `period_max`, `high_cnt`, `period_valid`, `sat`.
- `start` sampled high at edge T → MEAS from T+1, `busy` = 1 from T+1.
- Window covers edge-detector outputs at edges T+1 … T+GATE_CYCLES.
- DONE/`done` occurs at T+GATE_CYCLES+1; `busy` falls in that same cycle.
- **Input latency:** `sig_in` transition to detected edge is 2–3 `clk` cycles (synchronizer); applies equally to `high_cnt`.
- **Period rule:** interval = number of `clk` edges between consecutive detected edges. Example: a signal toggling every 4 cycles gives 8.
- **Boundary cases:**
  - Edge in the last MEAS cycle is counted.
  - Edge during DONE/IDLE is ignored.
  - `start` in DONE cycle is ignored.
  - Back-to-back `start` held high: new measurement begins the cycle after DONE.
- **Reset mid-measurement:** immediate return to IDLE, outputs cleared, no `done`.

## Test plan
- **Reset checks:** assert `rst` mid-MEAS → next cycle all outputs 0, `busy` 0, no `done` pulse afterwards.
- **Divide-by-8 input:** `sig_in` synchronous, toggles every 4 `clk`, GATE_CYCLES=1000, pulse `start` → `done` exactly 1001 cycles after `start`. Expected: `edge_cnt`=125, `period_min`=`period_max`=8, `high_cnt`=500±2, `period_valid`=1, `sat`=0.
- **Half-integer divider output:** divider configured N=13 feeding `sig_in`, GATE_CYCLES=1000 → `edge_cnt` ∈ {153,154}, `period_min`=6, `period_max`=7.
- **Static input:** `sig_in` held 1 (then repeated with 0) → `edge_cnt`=0, `period_valid`=0, `period_min`=0, `period_max`=0, `high_cnt`=1000 (resp. 0).
- **Saturation:** CNT_W=8, `sig_in` toggling every cycle, GATE_CYCLES=1000. Expected: `edge_cnt`=255, `high_cnt`=255, `sat`=1, `period_min`=`period_max`=2.
- **Handshake:** `start` pulsed during MEAS and during DONE → ignored; results identical to a single run. `start` held high → successive `done` pulses every 1002 cycles.
